// File: rtl/serial_fir_mac_if.sv
// Handshake/data bundle between the serial FIR MAC stage and its tap shift register.
// Latency: none, wires only.
// Backpressure: none; busy_o and drop_o report samples that arrive while a sweep is running.
interface serial_fir_mac_if #(
  parameter int DW = 12,
  parameter int AW = 4,
  parameter int OW = 28
);
  logic                 din_vld_i;
  logic                 en_o;
  logic [AW-1:0]        addr_o;
  logic signed [DW-1:0] tap_i;
  logic signed [OW-1:0] dout_o;
  logic                 dout_vld_o;
  logic                 busy_o;
  logic                 drop_o;

  // MAC stage side
  modport master (
    input  din_vld_i, tap_i,
    output en_o, addr_o, dout_o, dout_vld_o, busy_o, drop_o
  );

  // Shift register / sample source / result sink side
  modport slave (
    output din_vld_i, tap_i,
    input  en_o, addr_o, dout_o, dout_vld_o, busy_o, drop_o
  );
endinterface

// File: rtl/serial_fir_mac.sv
// Serial FIR control + multiply-accumulate: shifts a new sample in, sweeps all taps, emits the sum.
// Latency: din_vld_i accepted in cycle 0 -> dout_vld_o in cycle TAPS+1; one sample per TAPS+1 cycles.
// Backpressure: samples arriving mid-sweep are not shifted in and are flagged by a one-cycle drop_o.
module serial_fir_mac #(
  parameter int DW   = 12,
  parameter int CW   = 12,
  parameter int TAPS = 16,
  parameter int AW   = 4,
  parameter int OW   = DW + CW + AW,
  parameter logic [TAPS*CW-1:0] COEF = {TAPS{{{(CW-1){1'b0}}, 1'b1}}}
) (
  input logic              clk_i,
  input logic              rst_i,
  serial_fir_mac_if.master bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MAC  = 1'b1;

  logic [0:0]              state;
  logic signed [OW-1:0]    acc;
  logic signed [OW-1:0]    acc_nxt;
  logic signed [CW-1:0]    coef;
  logic signed [DW+CW-1:0] prod;
  logic                    last;

  // Unpack the coefficient vector so tap address k selects h[k] directly
  logic signed [CW-1:0] coef_tbl [TAPS];
  for (genvar k = 0; k < TAPS; k++) begin : g_coef
    assign coef_tbl[k] = COEF[k*CW +: CW];
  end

  // Product of the current tap and its coefficient, sign-extended into the accumulator
  always_comb begin
    coef    = coef_tbl[bus.addr_o];
    prod    = bus.tap_i * coef;
    acc_nxt = acc + $signed({{(OW-DW-CW){prod[DW+CW-1]}}, prod});
    last    = (bus.addr_o == AW'(TAPS - 1));
  end

  // Shift only when idle so the register captures the sample on the edge that starts the sweep
  assign bus.en_o   = bus.din_vld_i && (state == S_IDLE);
  assign bus.busy_o = (state == S_MAC);

  // Sweep sequencer, accumulator and registered result/pulse outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      acc            <= '0;
      bus.addr_o     <= '0;
      bus.dout_o     <= '0;
      bus.dout_vld_o <= 1'b0;
      bus.drop_o     <= 1'b0;
    end else begin
      bus.dout_vld_o <= 1'b0;
      bus.drop_o     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.din_vld_i) begin
            state      <= S_MAC;
            acc        <= '0;
            bus.addr_o <= '0;
          end
        end
        S_MAC: begin
          if (bus.din_vld_i) begin
            bus.drop_o <= 1'b1;
          end
          if (last) begin
            bus.dout_o     <= acc_nxt;
            bus.dout_vld_o <= 1'b1;
            bus.addr_o     <= '0;
            state          <= S_IDLE;
          end else begin
            acc        <= acc_nxt;
            bus.addr_o <= bus.addr_o + AW'(1);
          end
        end
        default: begin
          state      <= S_IDLE;
          bus.addr_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_fir_mac.sv
// Bench for serial_fir_mac: two instances (unit and worst-case coefficients) fed by tap shift-register models.
// Latency: expects each result exactly 17 cycles after its accepted sample.
// Backpressure: injects samples mid-sweep and expects drop pulses with no shift.
module tb_serial_fir_mac;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_vld = 1'b0;
  logic signed [11:0] din_dat = '0;

  int total = 0;
  int bad   = 0;

  serial_fir_mac_if #(.DW(12), .AW(4), .OW(28)) if_a ();
  serial_fir_mac_if #(.DW(12), .AW(4), .OW(28)) if_b ();

  serial_fir_mac dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
  serial_fir_mac #(.COEF({16{12'h800}})) dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));

  always #5 clk = ~clk;

  // Tap shift register models: tap 0 holds the newest accepted sample
  logic signed [11:0] sr_a [16];
  logic signed [11:0] sr_b [16];
  int en_cnt_a = 0;
  int en_cnt_b = 0;

  assign if_a.din_vld_i = din_vld;
  assign if_b.din_vld_i = din_vld;
  assign if_a.tap_i = sr_a[if_a.addr_o];
  assign if_b.tap_i = sr_b[if_b.addr_o];

  always @(posedge clk) begin
    if (if_a.en_o) begin
      for (int k = 15; k > 0; k--) sr_a[k] <= sr_a[k-1];
      sr_a[0] <= din_dat;
      en_cnt_a <= en_cnt_a + 1;
    end
    if (if_b.en_o) begin
      for (int k = 15; k > 0; k--) sr_b[k] <= sr_b[k-1];
      sr_b[0] <= din_dat;
      en_cnt_b <= en_cnt_b + 1;
    end
  end

  // Reference: history of accepted samples, newest first
  longint hist[$];

  function automatic longint ref_out(input bit worst);
    longint s = 0;
    longint h = worst ? -2048 : 1;
    for (int k = 0; k < hist.size() && k < 16; k++) s += h * hist[k];
    return s;
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " en_a"},   longint'(if_a.en_o), 0);
    chk({tag, " en_b"},   longint'(if_b.en_o), 0);
    chk({tag, " busy_a"}, longint'(if_a.busy_o), 0);
    chk({tag, " busy_b"}, longint'(if_b.busy_o), 0);
    chk({tag, " addr_a"}, longint'(if_a.addr_o), 0);
    chk({tag, " addr_b"}, longint'(if_b.addr_o), 0);
    chk({tag, " vld_a"},  longint'(if_a.dout_vld_o), 0);
    chk({tag, " vld_b"},  longint'(if_b.dout_vld_o), 0);
    chk({tag, " drop_a"}, longint'(if_a.drop_o), 0);
    chk({tag, " drop_b"}, longint'(if_b.drop_o), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      chk_quiet("idle");
    end
  endtask

  // Present sample x (caller is just after a negedge); optional drop attempt in sweep cycle drop_c (0 = none)
  task automatic send(input int x, input int drop_c);
    longint ea, eb;
    int ca, cb;
    din_dat = 12'(x);
    din_vld = 1'b1;
    #1;
    chk("accept en_a", longint'(if_a.en_o), 1);
    chk("accept en_b", longint'(if_b.en_o), 1);
    ca = en_cnt_a;
    cb = en_cnt_b;
    hist.push_front(longint'($signed(12'(x))));
    if (hist.size() > 16) void'(hist.pop_back());
    ea = ref_out(1'b0);
    eb = ref_out(1'b1);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      din_vld = (c == drop_c);
      #1;
      chk("sweep en_a",   longint'(if_a.en_o), 0);
      chk("sweep busy_a", longint'(if_a.busy_o), longint'(c < 17));
      chk("sweep busy_b", longint'(if_b.busy_o), longint'(c < 17));
      chk("sweep addr_a", longint'(if_a.addr_o), (c <= 16) ? c - 1 : 0);
      chk("sweep vld_a",  longint'(if_a.dout_vld_o), longint'(c == 17));
      chk("sweep vld_b",  longint'(if_b.dout_vld_o), longint'(c == 17));
      chk("sweep drop_a", longint'(if_a.drop_o), longint'(drop_c > 0 && c == drop_c + 1));
      chk("sweep drop_b", longint'(if_b.drop_o), longint'(drop_c > 0 && c == drop_c + 1));
      if (c == 17) begin
        chk("dout_a", longint'(if_a.dout_o), ea);
        chk("dout_b", longint'(if_b.dout_o), eb);
      end
    end
    chk("en_count_a", longint'(en_cnt_a - ca), 1);
    chk("en_count_b", longint'(en_cnt_b - cb), 1);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      sr_a[k] = '0;
      sr_b[k] = '0;
      hist.push_back(0);
    end

    // Reset state and quiet idle
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("reset");
    chk("reset dout_a", longint'(if_a.dout_o), 0);
    rst = 1'b0;
    idle(10);
    chk("idle dout_a", longint'(if_a.dout_o), 0);
    chk("idle dout_b", longint'(if_b.dout_o), 0);

    // Impulse response, back-to-back at full throughput
    send(2047, 0);
    for (int i = 0; i < 16; i++) send(0, 0);
    chk("impulse tail_a", longint'(if_a.dout_o), 0);

    // Negative fill: moving sum and worst-case coefficient products
    for (int i = 0; i < 16; i++) send(-2048, 0);
    chk("neg_fill_a", longint'(if_a.dout_o), -32768);
    chk("worst_b", longint'(if_b.dout_o), 67108864);
    idle(2);

    // Sample arriving while busy is dropped and does not disturb the result
    send(1234, 5);
    idle(1);

    // Asynchronous reset in the middle of a sweep
    din_dat = 12'sd700;
    din_vld = 1'b1;
    #1;
    chk("rst accept en_a", longint'(if_a.en_o), 1);
    hist.push_front(700);
    void'(hist.pop_back());
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      din_vld = 1'b0;
    end
    #1;
    chk("rst pre addr_a", longint'(if_a.addr_o), 8);
    rst = 1'b1;
    #1;
    chk_quiet("rst async");
    chk("rst dout_a", longint'(if_a.dout_o), 0);
    chk("rst dout_b", longint'(if_b.dout_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20);
    send(-555, 0);

    // Randomized samples, gaps and drop attempts
    for (int i = 0; i < 12; i++) begin
      int x;
      int dc;
      x  = int'($urandom_range(0, 4095)) - 2048;
      dc = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 14)) : 0;
      send(x, dc);
      idle(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
